// File: rtl/jtag_driver.sv
// On-chip JTAG master: serialises one IR/DR shift request onto TCK/TMS/TDI and gathers TDO.
// Optional JTAG_DRV_TRST_EN adds a TRST output pulsed for two TCK periods ahead of INIT.
module jtag_driver #(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = 6,
  parameter int CLK_DIV = 2
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               START,
  input  logic               IS_IR,
  input  logic [LEN_W-1:0]   LEN,
  input  logic [MAX_LEN-1:0] DATA_IN,
  output logic               BUSY,
  output logic               DONE,
  output logic [MAX_LEN-1:0] DATA_OUT,
  output logic               TCK,
  output logic               TMS,
  output logic               TDI,
  input  logic               TDO
`ifdef JTAG_DRV_TRST_EN
  ,
  output logic               TRST
`endif
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [LEN_W-1:0] LP_MAX = LEN_W'(MAX_LEN);

  typedef enum logic [2:0] {
    S_TRST,
    S_INIT,
    S_IDLE,
    S_SEL,
    S_SHIFT,
    S_UPD
  } state_t;

  state_t             r_state;
  logic [DIV_W-1:0]   r_div;
  logic [LEN_W-1:0]   r_cnt;
  logic [LEN_W-1:0]   r_len;
  logic               r_is_ir;
  logic [MAX_LEN-1:0] r_din;
  logic [MAX_LEN-1:0] r_dout;
  logic               r_tck;
  logic               r_tms;
  logic               r_tdi;
  logic               r_busy;
  logic               r_done;
`ifdef JTAG_DRV_TRST_EN
  logic               r_trst;
`endif

  logic               w_tick;
  logic               w_rise;
  logic               w_fall;
  logic               w_sel_last;
  logic [LEN_W-1:0]   w_len_clamp;
  logic [MAX_LEN-1:0] w_tdo_vec;

  assign w_tick      = (r_div == DIV_W'(CLK_DIV - 1));
  assign w_rise      = w_tick & ~r_tck;
  assign w_fall      = w_tick & r_tck;
  assign w_sel_last  = r_is_ir ? (r_cnt == LEN_W'(3)) : (r_cnt == LEN_W'(2));
  assign w_len_clamp = (LEN > LP_MAX) ? LP_MAX : LEN;
  assign w_tdo_vec   = {{(MAX_LEN-1){1'b0}}, TDO};

  // TCK toggles only outside IDLE; TMS/TDI advance on the CLK edge where TCK falls,
  // so each TCK cycle is low phase (new TMS/TDI) followed by high phase.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
`ifdef JTAG_DRV_TRST_EN
      r_state <= S_TRST;
      r_trst  <= 1'b1;
`else
      r_state <= S_INIT;
`endif
      r_div   <= '0;
      r_cnt   <= '0;
      r_len   <= '0;
      r_is_ir <= 1'b0;
      r_din   <= '0;
      r_dout  <= '0;
      r_tck   <= 1'b0;
      r_tms   <= 1'b1;
      r_tdi   <= 1'b0;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        r_div <= '0;
        r_tck <= 1'b0;
        if (START && (LEN != '0)) begin
          r_is_ir <= IS_IR;
          r_len   <= w_len_clamp;
          r_din   <= DATA_IN;
          r_busy  <= 1'b1;
          r_cnt   <= '0;
          r_tms   <= 1'b1;
          r_tdi   <= 1'b0;
          r_state <= S_SEL;
        end
      end else begin
        r_div <= w_tick ? '0 : r_div + DIV_W'(1);
        if (w_tick) begin
          r_tck <= ~r_tck;
        end
        // First sample of a scan clears the previous result.
        if (w_rise && (r_state == S_SHIFT)) begin
          r_dout <= ((r_cnt == '0) ? '0 : r_dout) | (w_tdo_vec << r_cnt);
        end
        if (w_fall) begin
          r_cnt <= r_cnt + LEN_W'(1);
          case (r_state)
`ifdef JTAG_DRV_TRST_EN
            S_TRST: begin
              if (r_cnt == LEN_W'(1)) begin
                r_trst  <= 1'b0;
                r_cnt   <= '0;
                r_state <= S_INIT;
              end
            end
`endif
            S_INIT: begin
              if (r_cnt == LEN_W'(5)) begin
                r_tms   <= 1'b0;
                r_busy  <= 1'b0;
                r_state <= S_IDLE;
              end else begin
                r_tms <= (r_cnt < LEN_W'(4));
              end
            end
            S_SEL: begin
              if (w_sel_last) begin
                r_cnt   <= '0;
                r_tms   <= (r_len == LEN_W'(1));
                r_tdi   <= r_din[0];
                r_state <= S_SHIFT;
              end else begin
                r_tms <= r_is_ir && (r_cnt == '0);
              end
            end
            S_SHIFT: begin
              if (r_cnt == (r_len - LEN_W'(1))) begin
                r_cnt   <= '0;
                r_tms   <= 1'b1;
                r_tdi   <= 1'b0;
                r_state <= S_UPD;
              end else begin
                r_din <= r_din >> 1;
                r_tdi <= r_din[1];
                r_tms <= ((r_cnt + LEN_W'(2)) == r_len);
              end
            end
            S_UPD: begin
              r_tms <= 1'b0;
              if (r_cnt == LEN_W'(1)) begin
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= S_IDLE;
              end
            end
            default: begin
              r_state <= S_IDLE;
            end
          endcase
        end
      end
    end
  end

  assign BUSY     = r_busy;
  assign DONE     = r_done;
  assign DATA_OUT = r_dout;
  assign TCK      = r_tck;
  assign TMS      = r_tms;
  assign TDI      = r_tdi;
`ifdef JTAG_DRV_TRST_EN
  assign TRST     = r_trst;
`endif

endmodule

// File: tb/tb_jtag_driver.sv
// Bench for jtag_driver: behavioural 1149.1 TAP target, scoreboard checked at each BUSY fall.
module tb_jtag_driver;

  localparam logic [31:0] ID_CODE  = 32'h1234_5A5B;
  localparam logic [3:0]  ID_INSTR = 4'b0010;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        START = 1'b0;
  logic        IS_IR = 1'b0;
  logic [5:0]  LEN = '0;
  logic [31:0] DATA_IN = '0;
  logic        BUSY, DONE, TCK, TMS, TDI;
  logic [31:0] DATA_OUT;
  logic        tdo = 1'b0;
`ifdef JTAG_DRV_TRST_EN
  logic        TRST;
`endif

  jtag_driver #(.MAX_LEN(32), .LEN_W(6), .CLK_DIV(2)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .IS_IR(IS_IR), .LEN(LEN),
    .DATA_IN(DATA_IN), .BUSY(BUSY), .DONE(DONE), .DATA_OUT(DATA_OUT),
    .TCK(TCK), .TMS(TMS), .TDI(TDI), .TDO(tdo)
`ifdef JTAG_DRV_TRST_EN
    , .TRST(TRST)
`endif
  );

  always #5 CLK = ~CLK;

  // ---------------- TAP target model ----------------
  typedef enum logic [3:0] {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PAUDR, EX2DR, UPDR,
                            SELIR, CAPIR, SHIR, EX1IR, PAUIR, EX2IR, UPIR} tap_t;
  tap_t        tap = TLR;
  logic [3:0]  ir = ID_INSTR;
  logic [3:0]  ir_sr = '0;
  logic [31:0] dr_sr = '0;

  function automatic tap_t tap_next(tap_t s, logic m);
    case (s)
      TLR:   return m ? TLR   : RTI;
      RTI:   return m ? SELDR : RTI;
      SELDR: return m ? SELIR : CAPDR;
      CAPDR: return m ? EX1DR : SHDR;
      SHDR:  return m ? EX1DR : SHDR;
      EX1DR: return m ? UPDR  : PAUDR;
      PAUDR: return m ? EX2DR : PAUDR;
      EX2DR: return m ? UPDR  : SHDR;
      UPDR:  return m ? SELDR : RTI;
      SELIR: return m ? TLR   : CAPIR;
      CAPIR: return m ? EX1IR : SHIR;
      SHIR:  return m ? EX1IR : SHIR;
      EX1IR: return m ? UPIR  : PAUIR;
      PAUIR: return m ? EX2IR : PAUIR;
      EX2IR: return m ? UPIR  : SHIR;
      UPIR:  return m ? SELDR : RTI;
      default: return TLR;
    endcase
  endfunction

  always @(posedge TCK) begin
    case (tap)
      TLR:   ir <= ID_INSTR;
      CAPIR: ir_sr <= 4'b0001;
      SHIR:  ir_sr <= {TDI, ir_sr[3:1]};
      UPIR:  ir <= ir_sr;
      CAPDR: dr_sr <= (ir == ID_INSTR) ? ID_CODE : 32'h0;
      SHDR:  if (ir == ID_INSTR) dr_sr <= {TDI, dr_sr[31:1]};
             else dr_sr[0] <= TDI;
      default: ;
    endcase
    tap <= tap_next(tap, TMS);
  end

  always @(negedge TCK) begin
    if (tap == SHDR)      tdo <= dr_sr[0];
    else if (tap == SHIR) tdo <= ir_sr[0];
    else                  tdo <= 1'b0;
  end

  // ---------------- trace capture ----------------
  int          tck_cnt = 0;
  logic [63:0] tms_trace = '0;
  logic [63:0] tdi_trace = '0;

  always @(posedge TCK) begin
    if (tck_cnt < 64) begin
      tms_trace[tck_cnt] = TMS;
      tdi_trace[tck_cnt] = TDI;
    end
    tck_cnt++;
  end

  task automatic clear_trace();
    tck_cnt   = 0;
    tms_trace = '0;
    tdi_trace = '0;
  endtask

  // ---------------- scoreboard ----------------
  int errs = 0;
  int checks = 0;

  typedef struct {
    string       name;
    bit          done;
    logic [31:0] data;
    int          tck;
    bit          trace;
    logic [63:0] tms;
    logic [63:0] tdi;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic prev_busy = 1'b1;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endfunction

  always @(negedge CLK) begin
    if (prev_busy && !BUSY) begin
      if (exp_q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_idle: got BUSY fall expected none");
      end else begin
        mon_e = exp_q.pop_front();
        chk({mon_e.name, "_done"}, 64'(DONE), 64'(mon_e.done));
        chk({mon_e.name, "_tck"}, 64'(tck_cnt), 64'(mon_e.tck));
        if (mon_e.done) chk({mon_e.name, "_data"}, 64'(DATA_OUT), 64'(mon_e.data));
        if (mon_e.trace) begin
          chk({mon_e.name, "_tms"}, tms_trace, mon_e.tms);
          chk({mon_e.name, "_tdi"}, tdi_trace, mon_e.tdi);
        end
      end
    end else if (DONE) begin
      checks++;
      errs++;
      $display("FAIL stray_done: got DONE=1 expected 0");
    end
    prev_busy = BUSY;
  end

  // ---------------- stimulus ----------------
  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      if (!BUSY) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errs++;
      $display("FAIL %s_timeout: got BUSY=1 expected 0 within 3000 cycles", name);
    end
    @(negedge CLK);
  endtask

  task automatic issue(input string name, input bit is_ir, input int len,
                       input logic [31:0] din, input logic [31:0] edata, input int etck,
                       input bit tr, input logic [63:0] etms, input logic [63:0] etdi,
                       input bit push);
    exp_t e;
    @(negedge CLK);
    if (push) begin
      e = '{name, 1'b1, edata, etck, tr, etms, etdi};
      exp_q.push_back(e);
    end
    clear_trace();
    START   = 1'b1;
    IS_IR   = is_ir;
    LEN     = 6'(len);
    DATA_IN = din;
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic push_init(input string name);
    exp_t e;
`ifdef JTAG_DRV_TRST_EN
    e = '{name, 1'b0, 32'h0, 8, 1'b1, 64'h7F, 64'h0};
`else
    e = '{name, 1'b0, 32'h0, 6, 1'b1, 64'h1F, 64'h0};
`endif
    exp_q.push_back(e);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge CLK);
    chk("rst_tck", 64'(TCK), 64'h0);
    chk("rst_tms", 64'(TMS), 64'h1);
    chk("rst_tdi", 64'(TDI), 64'h0);
    chk("rst_busy", 64'(BUSY), 64'h1);
    chk("rst_done", 64'(DONE), 64'h0);
    chk("rst_dout", 64'(DATA_OUT), 64'h0);
`ifdef JTAG_DRV_TRST_EN
    chk("rst_trst", 64'(TRST), 64'h1);
`endif

    // 1: init sequence
    push_init("init");
    clear_trace();
    RST_N = 1'b1;
    wait_idle("init");

    // 2: IR scan writes the ID instruction
    issue("ir_id", 1'b1, 4, 32'h2, 32'h1, 10, 1'b1, 64'h183, 64'h020, 1'b1);
    wait_idle("ir_id");
    chk("model_ir", 64'(ir), 64'(ID_INSTR));

    // 3: DR scan of the ID register
    issue("dr_id", 1'b0, 32, 32'h0, ID_CODE, 37, 1'b1, 64'hC_0000_0001, 64'h0, 1'b1);
    wait_idle("dr_id");

    // 4: BYPASS gives a one-bit delay
    issue("ir_byp", 1'b1, 4, 32'hF, 32'h1, 10, 1'b0, 64'h0, 64'h0, 1'b1);
    wait_idle("ir_byp");
    chk("model_ir_byp", 64'(ir), 64'hF);
    issue("dr_byp", 1'b0, 8, 32'hA5, 32'h4A, 13, 1'b1, 64'hC01, 64'h528, 1'b1);
    wait_idle("dr_byp");

    // 5: LEN=0 ignored, START while busy ignored, LEN=40 clamped to 32
    issue("len0", 1'b0, 0, 32'hFF, 32'h0, 0, 1'b0, 64'h0, 64'h0, 1'b0);
    repeat (20) @(negedge CLK);
    chk("len0_busy", 64'(BUSY), 64'h0);
    chk("len0_tck", 64'(tck_cnt), 64'h0);
    issue("dr_clamp", 1'b0, 40, 32'hDEAD_BEEF, 32'hBD5B_7DDE, 37, 1'b0, 64'h0, 64'h0, 1'b1);
    repeat (10) @(negedge CLK);
    START = 1'b1; IS_IR = 1'b1; LEN = 6'd4; DATA_IN = 32'h3;
    @(negedge CLK);
    START = 1'b0;
    wait_idle("dr_clamp");
    repeat (20) @(negedge CLK);
    chk("busy_start_ignored", 64'(BUSY), 64'h0);
    chk("model_ir_kept", 64'(ir), 64'hF);

    // 6: reset in the middle of a scan
    issue("dr_abort", 1'b0, 32, 32'hFFFF_FFFF, 32'h0, 0, 1'b0, 64'h0, 64'h0, 1'b0);
    for (int i = 0; i < 400 && tck_cnt < 14; i++) @(negedge CLK);
    chk("abort_reached_bit10", 64'(tck_cnt >= 14), 64'h1);
    RST_N = 1'b0;
    #1;
    chk("abort_tck", 64'(TCK), 64'h0);
    chk("abort_tms", 64'(TMS), 64'h1);
    chk("abort_tdi", 64'(TDI), 64'h0);
    chk("abort_done", 64'(DONE), 64'h0);
    chk("abort_busy", 64'(BUSY), 64'h1);
`ifdef JTAG_DRV_TRST_EN
    chk("abort_trst", 64'(TRST), 64'h1);
`endif
    push_init("reinit");
    clear_trace();
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    wait_idle("reinit");

    // Test-Logic-Reset restored the ID instruction
    issue("dr_id2", 1'b0, 32, 32'h0, ID_CODE, 37, 1'b0, 64'h0, 64'h0, 1'b1);
    wait_idle("dr_id2");
`ifdef JTAG_DRV_TRST_EN
    chk("trst_low", 64'(TRST), 64'h0);
`endif

    repeat (5) @(negedge CLK);
    chk("queue_empty", 64'(exp_q.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
